// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - multi-read-port register file with sequential clear and pending scoreboard
// Optional write-to-read forwarding selected by REGFILE_BYPASS_EN.
module param_register_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reg_write,
    input  logic [AW-1:0]       addrD,
    input  logic [XLEN-1:0]     dataD,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                pend_set,
    input  logic [AW-1:0]       pend_addr,
    output logic                ready
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];

    logic running;
    logic wr_valid;

    assign running  = (state_q == S_RUN);
    assign wr_valid = running && reg_write && (addrD != '0);
    assign ready    = ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        pend_d  = pend_q;
        regs_d  = regs_q;
        if (reset) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
            pend_d  = '0;
        end else if (state_q == S_CLEAR) begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end
        end else begin
            if (wr_valid) begin
                regs_d[addrD] = dataD;
                pend_d[addrD] = 1'b0;
            end
            // A new producer marked in the same cycle as a write keeps the register pending.
            if (pend_set && (pend_addr != '0)) begin
                pend_d[pend_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ready_q <= ready_d;
        pend_q  <= pend_d;
        regs_q  <= regs_d;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            if (running && (a != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_valid && (a == addrD)) begin
                    rd_data[k*XLEN +: XLEN] = dataD;
                    rd_busy[k]              = 1'b0;
                end else begin
                    rd_data[k*XLEN +: XLEN] = regs_q[a];
                    rd_busy[k]              = pend_q[a];
                end
`else
                rd_data[k*XLEN +: XLEN] = regs_q[a];
                rd_busy[k]              = pend_q[a];
`endif
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - directed self-checking bench for param_register_file
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  addrD;
    logic [31:0] dataD;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    param_register_file #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .addrD     (addrD),
        .dataD     (dataD),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .ready     (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic clear_sequence(input string tag);
        for (int e = 0; e < 32; e++) begin
            #1;
            check({tag, "_ready_low"}, 64'(ready), 64'd0);
            check({tag, "_data_zero"}, rd_data, 64'd0);
            check({tag, "_busy_zero"}, 64'(rd_busy), 64'd0);
            step();
        end
        check({tag, "_ready_high"}, 64'(ready), 64'd1);
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; addrD = '0; dataD = '0;
        rd_addr = '0; pend_set = 1'b0; pend_addr = '0;
        step();
        step();
        check("reset_ready", 64'(ready), 64'd0);
        reset = 1'b0;

        // Writes and pend_set held active through CLEAR must have no effect.
        reg_write = 1'b1; addrD = 5'd2; dataD = 32'hFFFF_FFFF;
        pend_set = 1'b1; pend_addr = 5'd2;
        rd_addr = {5'd2, 5'd31};
        clear_sequence("clr1");
        reg_write = 1'b0; pend_set = 1'b0;
        rd(5'd2, 5'd2);
        check("clr_ignored_data", rd_data, 64'd0);
        check("clr_ignored_busy", 64'(rd_busy), 64'd0);

        for (int i = 1; i < 32; i++) begin
            reg_write = 1'b1; addrD = 5'(i); dataD = 32'h1111_1111 + 32'(i);
            step();
        end
        reg_write = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(i));
            check("wr_rd_p0", 64'(rd_data[31:0]), 64'(32'h1111_1111 + 32'(i)));
            check("wr_rd_p1", 64'(rd_data[63:32]), 64'(32'h1111_1111 + 32'(i)));
        end
        reg_write = 1'b1; addrD = 5'd0; dataD = 32'hDEAD_BEEF;
        step();
        reg_write = 1'b0;
        rd(5'd0, 5'd0);
        check("r0_zero", rd_data, 64'd0);

        pend_set = 1'b1; pend_addr = 5'd5;
        step();
        pend_set = 1'b0;
        rd(5'd5, 5'd6);
        check("pend_busy", 64'(rd_busy), 64'b01);
        reg_write = 1'b1; addrD = 5'd5; dataD = 32'hA5A5_A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pend_wr_same_cycle_data", 64'(rd_data[31:0]), 64'hA5A5_A5A5);
        check("pend_wr_same_cycle_busy", 64'(rd_busy), 64'b00);
`else
        check("pend_wr_same_cycle_data", 64'(rd_data[31:0]), 64'h1111_1116);
        check("pend_wr_same_cycle_busy", 64'(rd_busy), 64'b01);
`endif
        step();
        reg_write = 1'b0;
        #1;
        check("pend_cleared_busy", 64'(rd_busy), 64'b00);
        check("pend_cleared_data", 64'(rd_data[31:0]), 64'hA5A5_A5A5);

        pend_set = 1'b1; pend_addr = 5'd7;
        reg_write = 1'b1; addrD = 5'd7; dataD = 32'h0000_1234;
        step();
        pend_set = 1'b0; reg_write = 1'b0;
        rd(5'd7, 5'd7);
        check("pend_wins_data", rd_data, {32'h0000_1234, 32'h0000_1234});
        check("pend_wins_busy", 64'(rd_busy), 64'b11);

        reg_write = 1'b1; addrD = 5'd9; dataD = 32'hCAFE_F00D;
        rd(5'd9, 5'd3);
`ifdef REGFILE_BYPASS_EN
        check("fwd_p0", 64'(rd_data[31:0]), 64'hCAFE_F00D);
`else
        check("fwd_p0", 64'(rd_data[31:0]), 64'h1111_111A);
`endif
        check("fwd_p1", 64'(rd_data[63:32]), 64'h1111_1114);
        step();
        reg_write = 1'b0;
        #1;
        check("fwd_after_edge", 64'(rd_data[31:0]), 64'hCAFE_F00D);

        // Reset from RUN, abort the clear at index 10, then run a full clear.
        reset = 1'b1;
        step();
        step();
        check("run_reset_ready", 64'(ready), 64'd0);
        reset = 1'b0;
        for (int e = 0; e < 10; e++) step();
        check("mid_clear_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd(5'd7, 5'd9);
        clear_sequence("clr2");
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            check("post_clear_data", rd_data, 64'd0);
            check("post_clear_busy", 64'(rd_busy), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
